// File: rtl/dmem_responder.sv
// Data-memory responder (data TCM): word RAM target of the core's mem_d request/accept/ack port.
// Latency: fixed LATENCY cycles from accept edge to ack; responses strictly in acceptance order.
// Backpressure: accept drops while MAX_OUTSTANDING responses are in flight; ack itself cannot be stalled.
//
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   mem_d_addr_i        - byte address (bits [1:0] ignored, bits above the RAM range flag an error)
//   mem_d_data_wr_i     - store data, written per enabled byte lane
//   mem_d_rd_i          - load request
//   mem_d_wr_i          - byte write enables (any set = store, store wins over load)
//   mem_d_cacheable_i   - unused, present for protocol compatibility
//   mem_d_req_tag_i     - request tag, echoed on the response
//   mem_d_invalidate_i, mem_d_writeback_i, mem_d_flush_i - maintenance requests (no RAM effect)
//   mem_d_data_rd_o     - load data (0 unless ack of a load)
//   mem_d_accept_o      - request can be taken this cycle (registered-count only)
//   mem_d_ack_o         - one-cycle response strobe
//   mem_d_error_o       - response is an out-of-range error
//   mem_d_resp_tag_o    - tag of the acknowledged request
module dmem_responder #(
  parameter int ADDR_W          = 14,
  parameter int LATENCY         = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_d_addr_i,
  input  logic [31:0] mem_d_data_wr_i,
  input  logic        mem_d_rd_i,
  input  logic [3:0]  mem_d_wr_i,
  input  logic        mem_d_cacheable_i,
  input  logic [10:0] mem_d_req_tag_i,
  input  logic        mem_d_invalidate_i,
  input  logic        mem_d_writeback_i,
  input  logic        mem_d_flush_i,
  output logic [31:0] mem_d_data_rd_o,
  output logic        mem_d_accept_o,
  output logic        mem_d_ack_o,
  output logic        mem_d_error_o,
  output logic [10:0] mem_d_resp_tag_o
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

  logic [3:0]        r_outstanding;
  logic [LATENCY-1:0] r_vld;
  logic [LATENCY-1:0] r_err;
  logic [10:0]       r_tag [LATENCY];
  logic [31:0]       r_dat [LATENCY];
  logic [31:0]       r_mem [0:(1<<ADDR_W)-1];

  logic              w_req;
  logic              w_acc;
  logic              w_ack;
  logic              w_oor;
  logic              w_store;
  logic              w_ram_we;
  logic [ADDR_W-1:0] w_idx;
  logic [31:0]       w_rsp_data;
  logic              w_rsp_err;
  logic              w_unused_bits;

  assign w_unused_bits = ^{mem_d_cacheable_i, mem_d_addr_i[1:0]};

  assign w_req = mem_d_rd_i | (|mem_d_wr_i) | mem_d_invalidate_i |
                 mem_d_writeback_i | mem_d_flush_i;
  // accept depends only on the registered count, never on this cycle's inputs
  assign mem_d_accept_o = (r_outstanding < MAX_CNT);
  assign w_acc   = w_req & mem_d_accept_o;
  assign w_ack   = r_vld[LATENCY-1];
  assign w_oor   = (mem_d_addr_i >> (ADDR_W + 2)) != 32'd0;
  assign w_store = |mem_d_wr_i;
  assign w_idx   = mem_d_addr_i[ADDR_W+1:2];
  // a store still being applied while reset asserts would be racing it; block it
  assign w_ram_we = w_acc & w_store & ~w_oor & ~rst;

  // response payload classified at acceptance: error > store > load > maintenance
  always_comb begin
    w_rsp_data = 32'd0;
    w_rsp_err  = 1'b0;
    if (w_oor) begin
      w_rsp_err = 1'b1;
    end else if (!w_store && mem_d_rd_i) begin
      w_rsp_data = r_mem[w_idx];
    end
  end

  // RAM contents survive reset
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_d_wr_i[b]) begin
          r_mem[w_idx][8*b +: 8] <= mem_d_data_wr_i[8*b +: 8];
        end
      end
    end
  end

  // slot is held through the ack cycle and freed from the cycle after
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outstanding <= 4'd0;
    end else begin
      case ({w_acc, w_ack})
        2'b10:   r_outstanding <= r_outstanding + 4'd1;
        2'b01:   r_outstanding <= r_outstanding - 4'd1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // response shift register; empty stages carry zeros so outputs are 0 while ack is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      r_err <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_tag[i] <= 11'd0;
        r_dat[i] <= 32'd0;
      end
    end else begin
      r_vld[0] <= w_acc;
      r_err[0] <= w_acc & w_rsp_err;
      r_tag[0] <= w_acc ? mem_d_req_tag_i : 11'd0;
      r_dat[0] <= w_acc ? w_rsp_data : 32'd0;
      for (int i = 1; i < LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_err[i] <= r_err[i-1];
        r_tag[i] <= r_tag[i-1];
        r_dat[i] <= r_dat[i-1];
      end
    end
  end

  assign mem_d_ack_o      = w_ack;
  assign mem_d_error_o    = r_err[LATENCY-1];
  assign mem_d_resp_tag_o = r_tag[LATENCY-1];
  assign mem_d_data_rd_o  = r_dat[LATENCY-1];

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed steps plus random traffic against a queue-based model.
// Instance A: LATENCY=2, MAX_OUTSTANDING=2. Instance B: LATENCY=4, MAX_OUTSTANDING=2 (accept pattern).
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
module tb_dmem_responder;

  localparam int AW     = 14;
  localparam int LAT    = 2;
  localparam int MAXO   = 2;
  localparam int LAT_B  = 4;
  localparam int MAXO_B = 2;

  logic clk = 1'b0;
  logic rst;

  logic [31:0] a_addr, a_wdat, a_rdat;
  logic        a_rd, a_inv, a_wb, a_fl, a_acc, a_ack, a_err;
  logic [3:0]  a_wr;
  logic [10:0] a_tag, a_rtag;

  logic [31:0] b_addr, b_wdat, b_rdat;
  logic        b_rd, b_acc, b_ack, b_err;
  logic [3:0]  b_wr;
  logic [10:0] b_tag, b_rtag;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(AW), .LATENCY(LAT), .MAX_OUTSTANDING(MAXO)) u_dut_a (
    .clk(clk), .rst(rst),
    .mem_d_addr_i(a_addr), .mem_d_data_wr_i(a_wdat), .mem_d_rd_i(a_rd), .mem_d_wr_i(a_wr),
    .mem_d_cacheable_i(1'b1), .mem_d_req_tag_i(a_tag),
    .mem_d_invalidate_i(a_inv), .mem_d_writeback_i(a_wb), .mem_d_flush_i(a_fl),
    .mem_d_data_rd_o(a_rdat), .mem_d_accept_o(a_acc), .mem_d_ack_o(a_ack),
    .mem_d_error_o(a_err), .mem_d_resp_tag_o(a_rtag)
  );

  dmem_responder #(.ADDR_W(AW), .LATENCY(LAT_B), .MAX_OUTSTANDING(MAXO_B)) u_dut_b (
    .clk(clk), .rst(rst),
    .mem_d_addr_i(b_addr), .mem_d_data_wr_i(b_wdat), .mem_d_rd_i(b_rd), .mem_d_wr_i(b_wr),
    .mem_d_cacheable_i(1'b0), .mem_d_req_tag_i(b_tag),
    .mem_d_invalidate_i(1'b0), .mem_d_writeback_i(1'b0), .mem_d_flush_i(1'b0),
    .mem_d_data_rd_o(b_rdat), .mem_d_accept_o(b_acc), .mem_d_ack_o(b_ack),
    .mem_d_error_o(b_err), .mem_d_resp_tag_o(b_rtag)
  );

  typedef struct {
    int          due;
    logic [10:0] tag;
    logic [31:0] data;
    bit          err;
    bit          dk;
  } rsp_t;

  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;
  rsp_t        q[$];
  rsp_t        bq[$];
  logic [31:0] mdl[int];

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", name, cyc, obs, exp);
    end
  endtask

  task automatic drive(input bit rd, input logic [3:0] wr, input logic [31:0] addr,
                       input logic [31:0] d, input logic [10:0] tag,
                       input bit inv, input bit wb, input bit fl);
    a_rd = rd; a_wr = wr; a_addr = addr; a_wdat = d; a_tag = tag;
    a_inv = inv; a_wb = wb; a_fl = fl;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 32'd0, 32'd0, 11'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // One cycle on instance A: check outputs against the model, let the model accept, clock.
  task automatic step(output bit accepted);
    bit          exp_acc, req;
    rsp_t        r;
    int          w;
    logic [31:0] t;
    exp_acc = (q.size() < MAXO);
    chk("accept", 32'(a_acc), 32'(exp_acc));
    if (q.size() > 0 && q[0].due == cyc) begin
      r = q.pop_front();
      chk("ack", 32'(a_ack), 32'd1);
      chk("resp_tag", 32'(a_rtag), 32'(r.tag));
      chk("resp_err", 32'(a_err), 32'(r.err));
      if (r.dk) chk("resp_data", a_rdat, r.data);
    end else begin
      chk("ack_idle", 32'(a_ack), 32'd0);
      chk("idle_data", a_rdat, 32'd0);
      chk("idle_tag_err", {20'd0, a_err, a_rtag}, 32'd0);
    end
    req = a_rd | (|a_wr) | a_inv | a_wb | a_fl;
    accepted = req && exp_acc;
    if (accepted) begin
      r.due = cyc + LAT; r.tag = a_tag; r.data = 32'd0; r.err = 1'b0; r.dk = 1'b1;
      w = int'(a_addr >> 2);
      if (a_addr >= (32'h1 << (AW + 2))) begin
        r.err = 1'b1;
      end else if (a_wr != 4'h0) begin
        if (a_wr == 4'hF) begin
          mdl[w] = a_wdat;
        end else if (mdl.exists(w)) begin
          t = mdl[w];
          for (int b = 0; b < 4; b++) if (a_wr[b]) t[8*b +: 8] = a_wdat[8*b +: 8];
          mdl[w] = t;
        end
      end else if (a_rd) begin
        if (mdl.exists(w)) r.data = mdl[w];
        else r.dk = 1'b0;
      end
      q.push_back(r);
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  // Present the driven request until the model accepts it, then go idle.
  task automatic issue();
    bit a;
    for (int i = 0; i < 20; i++) begin
      step(a);
      if (a) break;
    end
    idle();
  endtask

  task automatic run(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(a);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_ack", 32'(a_ack), 32'd0);
    chk("rst_err", 32'(a_err), 32'd0);
    chk("rst_data", a_rdat, 32'd0);
    chk("rst_tag", 32'(a_rtag), 32'd0);
    chk("rst_accept", 32'(a_acc), 32'd1);
    chk("rst_b_ack", 32'(b_ack), 32'd0);
    chk("rst_b_accept", 32'(b_acc), 32'd1);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=no_finish expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] words [8];
    logic [31:0] addr;
    bit          a;
    bit          bpat [8];
    int          bn;
    rsp_t        r;

    words = '{32'h0, 32'h1, 32'h40, 32'h41, 32'h1234, 32'h2000, 32'h3FFE, 32'h3FFF};
    bpat  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    rst = 1'b1;
    idle();
    b_rd = 1'b0; b_wr = 4'h0; b_addr = 32'd0; b_wdat = 32'd0; b_tag = 11'd0;
    do_reset();

    // store then load on the following cycle
    drive(1'b0, 4'hF, 32'h100, 32'hDEADBEEF, 11'h011, 1'b0, 1'b0, 1'b0); issue();
    drive(1'b1, 4'h0, 32'h100, 32'd0, 11'h012, 1'b0, 1'b0, 1'b0); issue();
    run(4);

    // partial byte-lane store merges into the existing word
    drive(1'b0, 4'b0101, 32'h100, 32'h11223344, 11'h013, 1'b0, 1'b0, 1'b0); issue();
    drive(1'b1, 4'h0, 32'h103, 32'd0, 11'h014, 1'b0, 1'b0, 1'b0); issue();
    run(4);

    // out-of-range load and store must not alias word 0
    drive(1'b0, 4'hF, 32'h0, 32'hCAFEF00D, 11'h001, 1'b0, 1'b0, 1'b0); issue();
    drive(1'b1, 4'h0, 32'h1 << (AW + 2), 32'd0, 11'h7FF, 1'b0, 1'b0, 1'b0); issue();
    drive(1'b0, 4'hF, 32'h1 << (AW + 2), 32'hFFFFFFFF, 11'h002, 1'b0, 1'b0, 1'b0); issue();
    drive(1'b1, 4'hF, 32'hFFFF0000, 32'h12345678, 11'h003, 1'b0, 1'b0, 1'b0); issue();
    drive(1'b1, 4'h0, 32'h0, 32'd0, 11'h004, 1'b0, 1'b0, 1'b0); issue();
    run(4);

    // maintenance requests leave RAM alone
    drive(1'b0, 4'h0, 32'h100, 32'hFFFFFFFF, 11'h005, 1'b0, 1'b0, 1'b1); issue();
    drive(1'b0, 4'h0, 32'h100, 32'hFFFFFFFF, 11'h006, 1'b1, 1'b1, 1'b0); issue();
    drive(1'b1, 4'h0, 32'h100, 32'd0, 11'h007, 1'b0, 1'b0, 1'b0); issue();
    run(4);

    // seed a small working set, then random traffic (requests change freely, including while refused)
    foreach (words[i]) begin
      drive(1'b0, 4'hF, words[i] << 2, $urandom, 11'(i), 1'b0, 1'b0, 1'b0); issue();
    end
    for (int i = 0; i < 400; i++) begin
      addr = (words[$urandom_range(0, 7)] << 2) | 32'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0, 1, 2: idle();
        3, 4, 5: drive(1'b1, 4'h0, addr, $urandom, 11'($urandom), 1'b0, 1'b0, 1'b0);
        6, 7:    drive(1'($urandom), 4'($urandom_range(1, 15)), addr, $urandom, 11'($urandom),
                       1'b0, 1'b0, 1'b0);
        8:       drive(1'b0, 4'h0, addr, $urandom, 11'($urandom),
                       1'($urandom), 1'($urandom), 1'b1);
        default: drive(1'($urandom), 4'($urandom), {16'($urandom_range(1, 65535)), 16'($urandom)},
                       $urandom, 11'($urandom), 1'b0, 1'b0, 1'b1);
      endcase
      step(a);
    end
    idle();
    run(4);

    // reset with two loads in flight: no acks, RAM keeps earlier stores
    drive(1'b0, 4'hF, 32'h200, 32'hA5A55A5A, 11'h020, 1'b0, 1'b0, 1'b0); issue();
    run(3);
    drive(1'b1, 4'h0, 32'h200, 32'd0, 11'h021, 1'b0, 1'b0, 1'b0); issue();
    drive(1'b1, 4'h0, 32'h200, 32'd0, 11'h022, 1'b0, 1'b0, 1'b0); issue();
    do_reset();
    run(4);
    drive(1'b1, 4'h0, 32'h200, 32'd0, 11'h023, 1'b0, 1'b0, 1'b0); issue();
    drive(1'b1, 4'h0, 32'h204, 32'd0, 11'h024, 1'b0, 1'b0, 1'b0); issue();
    run(4);

    // instance B: load held every cycle, LATENCY=4, two slots
    bn = 0;
    for (int c = 0; c < 16; c++) begin
      b_rd  = (c < 8);
      b_tag = 11'h100 + 11'(bn);
      if (c < 8) chk("b_accept", 32'(b_acc), 32'(bpat[c]));
      if (bq.size() > 0 && bq[0].due == c) begin
        r = bq.pop_front();
        chk("b_ack", 32'(b_ack), 32'd1);
        chk("b_resp_tag", 32'(b_rtag), 32'(r.tag));
      end else begin
        chk("b_ack_idle", 32'(b_ack), 32'd0);
      end
      if (c < 8 && bpat[c]) begin
        r.due = c + LAT_B; r.tag = b_tag; r.data = 32'd0; r.err = 1'b0; r.dk = 1'b0;
        bq.push_back(r);
        bn++;
      end
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the core's `mem_d_*` port: the target end of the data-side request/accept/ack protocol that the core drives as initiator. It holds a word-addressed RAM, accepts loads, byte-enabled stores and cache-maintenance requests, and returns in-order acknowledgements with the request tag after a fixed, parameterised latency. It is used in the core testbench and in small SoC builds as the data TCM.

## Interface

- `ADDR_W`, 14: word-address width; RAM depth is 2^ADDR_W 32-bit words.
- `LATENCY`, 2: accept-to-ack latency in cycles. Legal range is 1–8.
- `MAX_OUTSTANDING`, 2: maximum number of accepted but unacknowledged requests. Legal range is 1–8.

Reset is asynchronous and active-high; one clock domain.

- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous active-high reset.
- `mem_d_addr_i` in 32: byte address; bits [1:0] are ignored.
- `mem_d_data_wr_i` in 32: store data.
- `mem_d_rd_i` in 1: load request.
- `mem_d_wr_i` in 4: byte write enables; any bit set means a store.
- `mem_d_cacheable_i` in 1: ignored. It is accepted for protocol compatibility.
- `mem_d_req_tag_i` in 11: request tag, echoed on the response.
- `mem_d_invalidate_i`, `mem_d_writeback_i`, `mem_d_flush_i` in 1 each: cache-maintenance requests.
- `mem_d_data_rd_o` out 32: load data; valid while ack is high.
- `mem_d_accept_o` out 1: the responder can take a request this cycle.
- `mem_d_ack_o` out 1: response valid; held high for exactly one cycle per response.
- `mem_d_error_o` out 1: the response is an error; valid while ack is high.
- `mem_d_resp_tag_o` out 11: tag of the request being acknowledged.

## Operation

- **Request valid:** `req = mem_d_rd_i | (|mem_d_wr_i) | mem_d_invalidate_i | mem_d_writeback_i | mem_d_flush_i`.
- **Acceptance:** a request is accepted in a cycle where `req & mem_d_accept_o` is high at the rising edge.
- **Accept signal:** `mem_d_accept_o = (outstanding < MAX_OUTSTANDING)`. It is driven only from the registered count, with no combinational path from any input.
- **Outstanding counter:**
  - Increments on acceptance and decrements on each ack.
  - When both happen in the same cycle, the count is unchanged.
  - An ack leaving the block frees its slot from the following cycle.
- **Request classification at acceptance,** in priority order:
  1. Out of range: `mem_d_addr_i[31:ADDR_W+2] != 0` → error response. No RAM write, and read data is 0.
  2. Store (`|mem_d_wr_i`): write each enabled byte lane of `mem_d_data_wr_i` to `RAM[addr[ADDR_W+1:2]]` at the accept edge. Response carries data 0, no error. A request with both `rd` and `wr` set is treated as a store.
  3. Load: read `RAM[addr[ADDR_W+1:2]]` as of the accept edge. Stores accepted in earlier cycles are visible; the response data is captured at acceptance.
  4. Maintenance only (invalidate, writeback, flush): no RAM effect. Response carries data 0, no error.
- **Response pipeline:** a LATENCY-deep shift register carrying {valid, tag, data, error}. Responses are returned strictly in acceptance order.
- **RAM contents** are not reset.

## Timing

- **Reset values:** while `rst` is high, and immediately on its assertion, the outputs are:
  - `mem_d_ack_o = 0`
  - `mem_d_error_o = 0`
  - `mem_d_data_rd_o = 0`
  - `mem_d_resp_tag_o = 0`
  - `mem_d_accept_o = 1` (outstanding = 0)
- **Latency:** a request accepted at the edge ending cycle t has ack high in cycle t+LATENCY. With LATENCY=1, ack is in the next cycle.
- **Back-to-back requests:** one request per cycle is allowed. Throughput is one request per cycle when `MAX_OUTSTANDING >= LATENCY + 1`; otherwise accept drops once the count hits the limit.
- **Ack backpressure:** none. The initiator must always consume ack.
- **Outputs while ack is low:** `mem_d_data_rd_o`, `mem_d_error_o` and `mem_d_resp_tag_o` are 0.
- **Reset mid-operation:** all in-flight responses are discarded without ack. Stores already accepted remain in RAM.
- **Request while accept is low:** ignored, with no side effect. The initiator holds the request.

## Test plan

- **Store then load:** reset with LATENCY=2. Store `0xDEADBEEF` to addr `0x100`, wr=`4'hF`, tag `0x011`; next cycle load addr `0x100`, tag `0x012`.
  - Ack with tag `0x011`, data 0, two cycles after the store.
  - Ack with tag `0x012`, data `0xDEADBEEF`, one cycle after that.
- **Byte enables:** RAM word at `0x100` = `0xDEADBEEF`. Store `0x11223344` with wr=`4'b0101`, then load.
  - Read data is `0xDE22BE44`.
- **Out of range:** load from addr `1<<(ADDR_W+2)`, tag `0x7FF`.
  - Ack with error=1, data 0, tag `0x7FF`.
  - A store to the same address does not alias or corrupt word 0.
- **Outstanding limit:** LATENCY=4, MAX_OUTSTANDING=2, load held asserted every cycle.
  - Accept pattern over cycles 0–7 is 1,1,0,0,0,1,1,0.
  - Acks arrive in order.
  - Tags match the accepted requests.
- **Maintenance request:** flush=1 with tag `0x005`, rd=0, wr=0.
  - Ack after LATENCY cycles with data 0, error 0, tag `0x005`.
  - RAM is unchanged.
- **Reset mid-flight:** accept two loads, then assert `rst` one cycle later.
  - No acks appear.
  - After release, accept=1 and outstanding=0.
  - Data from earlier stores still reads back.
